// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with a two-entry skid buffer.
// The main entry drives mem_*; the skid entry catches one instruction that
// arrives while data memory stalls. Store byte-enables, lane-replicated data
// and the misalignment flag are computed at capture and held with the entry.
// Optional feature macro: EXMEM_FWD_EN adds the fwd_* forwarding port.
//
// state | meaning
// EMPTY | no entry held (main and skid invalid)
// ONE   | main entry valid, skid empty
// TWO   | main and skid valid, ex_ready low
module ex_mem_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [31:0] ex_alu_res,
   input  logic [31:0] ex_rs2o,
   input  logic [31:0] ex_pc4,
   input  logic [4:0]  ex_rdaddr,
   input  logic [2:0]  ex_func3,
   input  logic        ex_memwr,
   input  logic        ex_regwr,
   input  logic [1:0]  ex_wbsel,
   input  logic        mem_stall,
   input  logic        flush,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   output logic        mem_memwr,
   output logic        mem_regwr,
   output logic [4:0]  mem_rdaddr,
   output logic [2:0]  mem_func3,
   output logic [1:0]  mem_wbsel,
   output logic [31:0] mem_pc4,
   output logic        mem_misalign
`ifdef EXMEM_FWD_EN
   ,
   output logic        fwd_valid,
   output logic [4:0]  fwd_rdaddr,
   output logic [31:0] fwd_data
`endif
);

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] pc4;
      logic [4:0]  rdaddr;
      logic [2:0]  func3;
      logic        memwr;
      logic        regwr;
      logic [1:0]  wbsel;
      logic [3:0]  be;
      logic        misalign;
   } entry_t;

   entry_t main_q, main_d, skid_q, skid_d, new_e;
   logic   main_valid_q, main_valid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   accept;
   logic   head_valid;

   // Format the incoming instruction into an entry (store lanes, enables, misalign).
   always_comb begin
      logic [3:0] be_raw;
      logic       mis;
      new_e          = '0;
      new_e.addr     = ex_alu_res;
      new_e.pc4      = ex_pc4;
      new_e.rdaddr   = ex_rdaddr;
      new_e.func3    = ex_func3;
      new_e.memwr    = ex_memwr;
      new_e.regwr    = ex_regwr;
      new_e.wbsel    = ex_wbsel;
      new_e.wdata    = ex_rs2o;
      be_raw         = 4'b0000;
      mis            = 1'b0;
      if (ex_memwr) begin
         case (ex_func3[1:0])
            2'b00: begin
               be_raw      = 4'b0001 << ex_alu_res[1:0];
               new_e.wdata = {4{ex_rs2o[7:0]}};
            end
            2'b01: begin
               be_raw      = ex_alu_res[1] ? 4'b1100 : 4'b0011;
               new_e.wdata = {2{ex_rs2o[15:0]}};
               mis         = ex_alu_res[0];
            end
            2'b10: begin
               be_raw      = 4'b1111;
               mis         = (ex_alu_res[1:0] != 2'b00);
            end
            default: be_raw = 4'b0000;
         endcase
      end
      new_e.misalign = mis;
      new_e.be       = mis ? 4'b0000 : be_raw;
   end

   assign ex_ready = !skid_valid_q;
   assign accept   = ex_valid & ex_ready & !flush;

   // Next state: move entries between EX, skid and main based on accept/stall/flush.
   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else begin
         case ({main_valid_q, skid_valid_q})
            2'b00: begin
               if (accept) begin
                  main_d       = new_e;
                  main_valid_d = 1'b1;
               end
            end
            2'b10: begin
               if (accept && mem_stall) begin
                  skid_d       = new_e;
                  skid_valid_d = 1'b1;
               end else if (accept) begin
                  main_d = new_e;
               end else if (!mem_stall) begin
                  main_valid_d = 1'b0;
               end
            end
            2'b11: begin
               if (!mem_stall) begin
                  main_d       = skid_q;
                  skid_valid_d = 1'b0;
               end
            end
            default: begin
               main_valid_d = 1'b0;
               skid_valid_d = 1'b0;
            end
         endcase
      end
   end

   // State register with synchronous reset; data fields also cleared so mem_* read 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   // The head is suppressed during the reset cycle so no write escapes mid-reset.
   assign head_valid = main_valid_q & !rst;

   // Output decode: qualifiers gated by head valid, data fields straight from main.
   always_comb begin
      mem_valid    = head_valid;
      mem_addr     = main_q.addr;
      mem_wdata    = main_q.wdata;
      mem_pc4      = main_q.pc4;
      mem_rdaddr   = main_q.rdaddr;
      mem_func3    = main_q.func3;
      mem_wbsel    = main_q.wbsel;
      mem_be       = head_valid ? main_q.be : 4'b0000;
      mem_memwr    = head_valid & main_q.memwr & !main_q.misalign;
      mem_regwr    = head_valid & main_q.regwr;
      mem_misalign = head_valid & main_q.misalign;
   end

`ifdef EXMEM_FWD_EN
   // Forward ALU / link results of the head; loads (wbsel 1) and x0 never forward.
   always_comb begin
      fwd_rdaddr = main_q.rdaddr;
      fwd_valid  = head_valid & main_q.regwr & (main_q.rdaddr != 5'd0) & (main_q.wbsel != 2'd1);
      fwd_data   = (main_q.wbsel == 2'd2) ? main_q.pc4 : main_q.addr;
   end
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: store formatting, skid/stall ordering,
// flush and mid-stall reset. Forwarding checks build with EXMEM_FWD_EN.
module tb_ex_mem_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_alu_res, ex_rs2o, ex_pc4;
   logic [4:0]  ex_rdaddr;
   logic [2:0]  ex_func3;
   logic        ex_memwr, ex_regwr;
   logic [1:0]  ex_wbsel;
   logic        mem_stall, flush;
   logic        mem_valid;
   logic [31:0] mem_addr, mem_wdata, mem_pc4;
   logic [3:0]  mem_be;
   logic        mem_memwr, mem_regwr, mem_misalign;
   logic [4:0]  mem_rdaddr;
   logic [2:0]  mem_func3;
   logic [1:0]  mem_wbsel;
`ifdef EXMEM_FWD_EN
   logic        fwd_valid;
   logic [4:0]  fwd_rdaddr;
   logic [31:0] fwd_data;
`endif

   int n_asserts = 0;
   int n_fails   = 0;

   always #5 clk = ~clk;

   ex_mem_reg dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_alu_res(ex_alu_res), .ex_rs2o(ex_rs2o), .ex_pc4(ex_pc4),
      .ex_rdaddr(ex_rdaddr), .ex_func3(ex_func3), .ex_memwr(ex_memwr),
      .ex_regwr(ex_regwr), .ex_wbsel(ex_wbsel), .mem_stall(mem_stall),
      .flush(flush), .mem_valid(mem_valid), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_memwr(mem_memwr),
      .mem_regwr(mem_regwr), .mem_rdaddr(mem_rdaddr), .mem_func3(mem_func3),
      .mem_wbsel(mem_wbsel), .mem_pc4(mem_pc4), .mem_misalign(mem_misalign)
`ifdef EXMEM_FWD_EN
      , .fwd_valid(fwd_valid), .fwd_rdaddr(fwd_rdaddr), .fwd_data(fwd_data)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rs2,
                        input logic [31:0] pc4, input logic [4:0] rd, input logic [2:0] f3,
                        input logic mw, input logic rw, input logic [1:0] wb);
      ex_valid   = v;
      ex_alu_res = alu;
      ex_rs2o    = rs2;
      ex_pc4     = pc4;
      ex_rdaddr  = rd;
      ex_func3   = f3;
      ex_memwr   = mw;
      ex_regwr   = rw;
      ex_wbsel   = wb;
   endtask

   initial begin
      rst = 1'b1; mem_stall = 1'b0; flush = 1'b0;
      drive(1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 2'd0);
      tick(); tick();
      chk("rst_valid", {31'd0, mem_valid}, 32'd0);
      chk("rst_ready", {31'd0, ex_ready}, 32'd1);
      chk("rst_be", {28'd0, mem_be}, 32'd0);
      chk("rst_memwr", {31'd0, mem_memwr}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      rst = 1'b0;

      // SW aligned
      drive(1'b1, 32'h100, 32'hDEADBEEF, 32'h4, 5'd0, 3'b010, 1'b1, 1'b0, 2'd0);
      tick();
      chk("sw_valid", {31'd0, mem_valid}, 32'd1);
      chk("sw_memwr", {31'd0, mem_memwr}, 32'd1);
      chk("sw_be", {28'd0, mem_be}, 32'hF);
      chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
      chk("sw_addr", mem_addr, 32'h100);
      // SB at byte 3
      drive(1'b1, 32'h103, 32'h12345678, 32'h8, 5'd0, 3'b000, 1'b1, 1'b0, 2'd0);
      tick();
      chk("sb_be", {28'd0, mem_be}, 32'h8);
      chk("sb_wdata", mem_wdata, 32'h78787878);
      // SH upper half
      drive(1'b1, 32'h102, 32'h12345678, 32'hC, 5'd0, 3'b001, 1'b1, 1'b0, 2'd0);
      tick();
      chk("sh_be", {28'd0, mem_be}, 32'hC);
      chk("sh_wdata", mem_wdata, 32'h56785678);
      // SW misaligned
      drive(1'b1, 32'h101, 32'h12345678, 32'h10, 5'd0, 3'b010, 1'b1, 1'b0, 2'd0);
      tick();
      chk("mis_flag", {31'd0, mem_misalign}, 32'd1);
      chk("mis_memwr", {31'd0, mem_memwr}, 32'd0);
      chk("mis_be", {28'd0, mem_be}, 32'd0);
      chk("mis_valid", {31'd0, mem_valid}, 32'd1);
      // drain to EMPTY
      ex_valid = 1'b0;
      tick();
      chk("drain_valid", {31'd0, mem_valid}, 32'd0);
      chk("drain_mis", {31'd0, mem_misalign}, 32'd0);
      chk("drain_be", {28'd0, mem_be}, 32'd0);

      // A, B, C with a two-cycle stall after A lands
      drive(1'b1, 32'hA, 32'h11223344, 32'h14, 5'd1, 3'b000, 1'b0, 1'b1, 2'd0);
      tick();
      chk("A_addr", mem_addr, 32'hA);
      chk("A_regwr", {31'd0, mem_regwr}, 32'd1);
      chk("A_wdata_raw", mem_wdata, 32'h11223344);
      chk("A_be", {28'd0, mem_be}, 32'd0);
      mem_stall = 1'b1;
      drive(1'b1, 32'hB, 32'h0, 32'h18, 5'd2, 3'b000, 1'b0, 1'b1, 2'd0);
      tick();
      chk("stall1_addr", mem_addr, 32'hA);
      chk("stall1_ready", {31'd0, ex_ready}, 32'd0);
      drive(1'b1, 32'hC, 32'h0, 32'h1C, 5'd3, 3'b000, 1'b0, 1'b1, 2'd0);
      tick();
      chk("stall2_addr", mem_addr, 32'hA);
      chk("stall2_ready", {31'd0, ex_ready}, 32'd0);
      mem_stall = 1'b0;
      tick();
      chk("B_addr", mem_addr, 32'hB);
      chk("B_rd", {27'd0, mem_rdaddr}, 32'd2);
      chk("B_ready", {31'd0, ex_ready}, 32'd1);
      tick();
      chk("C_addr", mem_addr, 32'hC);
      chk("C_rd", {27'd0, mem_rdaddr}, 32'd3);
      ex_valid = 1'b0;
      tick();
      chk("abc_end_valid", {31'd0, mem_valid}, 32'd0);

      // flush in TWO with stall and ex_valid high
      drive(1'b1, 32'h200, 32'h1, 32'h20, 5'd0, 3'b010, 1'b1, 1'b0, 2'd0);
      tick();
      mem_stall = 1'b1;
      drive(1'b1, 32'h204, 32'h2, 32'h24, 5'd0, 3'b010, 1'b1, 1'b0, 2'd0);
      tick();
      chk("two_ready", {31'd0, ex_ready}, 32'd0);
      flush = 1'b1;
      drive(1'b1, 32'h208, 32'h3, 32'h28, 5'd0, 3'b010, 1'b1, 1'b0, 2'd0);
      tick();
      chk("flush_valid", {31'd0, mem_valid}, 32'd0);
      chk("flush_ready", {31'd0, ex_ready}, 32'd1);
      chk("flush_memwr", {31'd0, mem_memwr}, 32'd0);
      flush = 1'b0; mem_stall = 1'b0; ex_valid = 1'b0;
      tick();
      chk("post_flush_valid", {31'd0, mem_valid}, 32'd0);

      // reset in the middle of a stall
      drive(1'b1, 32'h300, 32'h5, 32'h30, 5'd0, 3'b010, 1'b1, 1'b0, 2'd0);
      tick();
      mem_stall = 1'b1;
      drive(1'b1, 32'h304, 32'h6, 32'h34, 5'd0, 3'b010, 1'b1, 1'b0, 2'd0);
      tick();
      chk("pre_rst_memwr", {31'd0, mem_memwr}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_cycle_memwr", {31'd0, mem_memwr}, 32'd0);
      tick();
      chk("rst_mid_valid", {31'd0, mem_valid}, 32'd0);
      chk("rst_mid_ready", {31'd0, ex_ready}, 32'd1);
      chk("rst_mid_addr", mem_addr, 32'd0);
      rst = 1'b0; mem_stall = 1'b0;

`ifdef EXMEM_FWD_EN
      drive(1'b1, 32'd42, 32'h0, 32'h40, 5'd5, 3'b000, 1'b0, 1'b1, 2'd0);
      tick();
      chk("fwd_add_valid", {31'd0, fwd_valid}, 32'd1);
      chk("fwd_add_rd", {27'd0, fwd_rdaddr}, 32'd5);
      chk("fwd_add_data", fwd_data, 32'd42);
      drive(1'b1, 32'h400, 32'h0, 32'h44, 5'd5, 3'b010, 1'b0, 1'b1, 2'd1);
      tick();
      chk("fwd_load", {31'd0, fwd_valid}, 32'd0);
      drive(1'b1, 32'h7, 32'h0, 32'h48, 5'd0, 3'b000, 1'b0, 1'b1, 2'd0);
      tick();
      chk("fwd_x0", {31'd0, fwd_valid}, 32'd0);
      drive(1'b1, 32'h9, 32'h0, 32'h104, 5'd3, 3'b000, 1'b0, 1'b1, 2'd2);
      tick();
      chk("fwd_link_valid", {31'd0, fwd_valid}, 32'd1);
      chk("fwd_link_data", fwd_data, 32'h104);
      ex_valid = 1'b0;
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

EX/MEM pipeline register with a two-entry skid buffer, between the execute stage and data memory. Accepts one instruction per cycle from EX and holds it while data memory stalls. Formats store byte-enables and data, and flags misaligned stores. Optionally drives a forwarding port back to EX.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX presents an instruction this cycle
- ex_ready  out  1  register can accept (= !skid_valid); combinational from state
- ex_alu_res  in  32  ALU result / memory address
- ex_rs2o  in  32  store data (raw rs2)
- ex_pc4  in  32  PC+4 for link writeback
- ex_rdaddr  in  5  destination register
- ex_func3  in  3  instruction func3
- ex_memwr  in  1  store
- ex_regwr  in  1  register writeback
- ex_wbsel  in  2  0 = ALU, 1 = memory, 2 = PC+4
- mem_stall  in  1  data memory cannot take head entry this cycle
- flush  in  1  kill all held and incoming entries
- mem_valid  out  1  head entry valid
- mem_addr  out  32  head ALU result
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables; 0 when not a valid store
- mem_memwr  out  1  valid & store & !misaligned
- mem_regwr  out  1  valid & regwr
- mem_rdaddr, mem_func3, mem_wbsel, mem_pc4  out  5/3/2/32  head fields
- mem_misalign  out  1  head is a valid misaligned store
- fwd_valid, fwd_rdaddr, fwd_data  out  1/5/32  forwarding port (EXMEM_FWD_EN only)

## Operation
- Accept condition: ex_valid & ex_ready & !flush.
- Storage: main entry (drives mem_*) and skid entry, each with a valid bit.
- States, encoded by the valid bits: EMPTY (none), ONE (main), TWO (main+skid).
- EMPTY: accept → ONE.
- ONE, main unchanged: !accept & mem_stall.
- ONE, main ← new: accept & !mem_stall.
- ONE → TWO: accept & mem_stall; new entry goes to skid.
- ONE → EMPTY: !accept & !mem_stall.
- TWO: ex_ready=0. !mem_stall → ONE (skid moves to main). mem_stall → hold.
- flush (any state): both valids cleared next cycle; no accept that cycle. Overrides mem_stall and ex_valid.
- Store formatting, computed at capture and stored with the entry:
  - func3[1:0]=00 (SB): be = 1<<addr[1:0], wdata = {4{rs2[7:0]}}
  - 01 (SH): be = addr[1] ? 1100 : 0011, wdata = {2{rs2[15:0]}}
  - 10 (SW): be = 1111, wdata = rs2
  - 11: be = 0000
- Misaligned store: SH with addr[0]=1, or SW with addr[1:0]≠0.
  - mem_memwr=0 and mem_be=0; mem_misalign=1 while the entry is head.
- Non-store entries: mem_wdata = rs2 unformatted; be = 0.
- All mem_* qualifiers (memwr, regwr, be, misalign) are 0 when mem_valid=0. Data fields keep their last value.

## Timing
- Reset: all valids 0 (EMPTY), so ex_ready=1. All mem_* outputs 0, fwd_valid=0. rst overrides flush and ex_valid.
- Latency: an accepted instruction appears on mem_* the next cycle when EMPTY or ONE with !mem_stall.
- Throughput: 1 per cycle with mem_stall low. A single mem_stall cycle costs one cycle, with no loss and no duplication.
- ex_ready falls the cycle after entering TWO. It rises the cycle after TWO → ONE.
- Order is strict FIFO; an entry is never dropped except by flush or rst.
- Reset mid-stall discards both entries; no memory write is issued in the reset cycle.

## Configuration
- EXMEM_FWD_EN defined: fwd_rdaddr = mem_rdaddr.
  - fwd_valid = mem_valid & mem_regwr & (rdaddr≠0) & (wbsel≠1).
  - fwd_data = wbsel==2 ? pc4 : alu_res.
  - Loads are never forwarded.
- EXMEM_FWD_EN undefined: fwd_* ports absent and no forwarding logic is built.

## Test plan
- Reset, then SW: addr 0x100, rs2 0xDEADBEEF → next cycle mem_memwr=1, be=1111, wdata=0xDEADBEEF.
- SB: addr 0x103, rs2 0x12345678 → be=1000, wdata=0x78787878. SH: addr 0x102 → be=1100, wdata=0x56785678.
- SW: addr 0x101 → mem_misalign=1, mem_memwr=0, be=0000, mem_valid=1.
- Back-to-back A, B, C with mem_stall high 2 cycles after A lands:
  - B goes to skid, ex_ready=0, C held upstream.
  - Outputs in order A, B, C with none lost or duplicated.
- In TWO, assert flush together with mem_stall and ex_valid → next cycle mem_valid=0, ex_ready=1, no write.
- EXMEM_FWD_EN, ADD: rd=5, res 42 → fwd_valid=1, fwd_rdaddr=5, fwd_data=42.
  - LW: rd=5 → fwd_valid=0. Any writer with rd=0 → fwd_valid=0.
